sprite_register_bank: RTL and testbench
=======================================

Name: sprite_register_bank

Overview:
- Sprite attribute store and coordinate-lookup stage, directly upstream of the pixel print stage.
- The print stage presents packed pixel coordinates as check_value {x[17:9], y[8:0]}.
- This block scans its sprite slots sequentially and returns data_reg: the memory offset of the covering sprite, or BG_CODE when the pixel is background.
- Slots are written by the host/processor side through a simple write port.

Parameters:
- NUM_SPRITES, 32, number of sprite slots; slot index width is 5 bits.
- SPRITE_SIZE, 20, sprite width and height in pixels (square sprites).
- BG_CODE, 9'd1, data_reg value returned when no sprite covers the pixel.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- wr_en  in  1  slot write strobe
- wr_addr  in  5  slot index to write
- wr_data  in  28  slot contents: [27] active, [26:18] sprite offset, [17:9] sprite x, [8:0] sprite y
- lookup_valid  in  1  request lookup of check_value
- check_value  in  18  pixel coordinate: [17:9] pixel x, [8:0] pixel y
- busy  out  1  lookup in progress; new requests are ignored while high
- data_valid  out  1  one-cycle pulse marking data_reg/hit_row as valid
- data_reg  out  9  sprite offset of the winning slot, or BG_CODE
- hit_row  out  5  pixel_y − sprite_y of the winning slot; 0 on background

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-low.
- Reset values:
  - all slots: active=0, other fields 0
  - busy=0, data_valid=0, data_reg=BG_CODE, hit_row=0
  - FSM state = IDLE
- Reset asserted mid-scan aborts the lookup; no data_valid pulse is produced.
- FSM states:
  - IDLE: on lookup_valid=1, latch check_value, clear slot counter to 0, go to SCAN, busy=1 from the next cycle.
  - SCAN: examine slot[counter] each cycle.
    - Hit: go to DONE, latch that slot's offset and row.
    - Counter == NUM_SPRITES−1 with no hit: go to DONE with BG_CODE and row 0.
    - Otherwise: increment counter.
  - DONE: data_valid=1 for exactly one cycle with registered data_reg/hit_row, then return to IDLE (busy=0).
- Hit test, evaluated in 10-bit unsigned arithmetic to avoid wrap: active && px >= sx && px < sx+SPRITE_SIZE && py >= sy && py < sy+SPRITE_SIZE.
  - Example: a sprite at x=470 extends to 489 with no wrap to 0.
- Priority: the lowest slot index wins.
- Latency:
  - request accepted at edge 0
  - hit in slot k → data_valid high in cycle k+2
  - full miss → data_valid high in cycle NUM_SPRITES+1
- data_reg and hit_row hold their values after data_valid falls until the next result.
- lookup_valid while busy=1 (SCAN or DONE) is ignored, not queued.
- lookup_valid is sampled in the same cycle that DONE returns to IDLE is not possible; the earliest accept is the first IDLE cycle.
- Writes:
  - accepted any cycle, including during SCAN; visible from the next cycle.
  - a write to the slot being examined in the same cycle does not affect that examination (old value used).
  - writes to already-scanned slots do not affect the current result.
- Software must not program an active slot with offset == BG_CODE; the result would be indistinguishable from background. Hardware does not check this.

Optional Feature:
- Macro: SPRITE_COLLISION_EN.
- When defined:
  - adds output port collision (1 bit, reset 0)
  - SCAN never exits early and always examines all NUM_SPRITES slots
  - the first hit still determines data_reg/hit_row
  - collision=1 alongside data_valid when two or more slots hit; valid with data_valid, held until the next result
  - fixed latency: data_valid in cycle NUM_SPRITES+1
- When undefined: port absent; early exit on first hit as described in Behaviour.

Test Plan:
- Reset mid-scan: assert reset during SCAN → busy=0, data_valid=0, data_reg=9'd1 immediately (asynchronous); after release, all slots read as inactive.
- Background lookup: no slots written; lookup check_value={x=100,y=50} → data_valid in cycle 33, data_reg=1, hit_row=0.
- Single hit: slot 3 = {active=1, offset=9'd40, x=100, y=50}; lookup {x=119,y=69} → data_valid in cycle 5, data_reg=40, hit_row=19. Lookup {x=120,y=69} → miss, data_reg=1.
- Priority and ignored request: slots 2 and 7 both cover {x=10,y=10} with offsets 5 and 9 → data_reg=5. A second lookup_valid while busy=1 produces no extra data_valid pulse.
- Edge wrap and write during scan: slot 0 at x=470 with lookup x=5 → miss. Write slot 10 during SCAN while counter=4 → new contents are used (hit). Write slot 2 during the same scan → not used.
- SPRITE_COLLISION_EN build: the priority scenario above → collision=1, data_valid in cycle 33; a single-hit case → collision=0.

Source files
------------

// File: rtl/sprite_register_bank.sv
// Sprite attribute store with a sequential coordinate lookup for the pixel print stage.
// Optional SPRITE_COLLISION_EN: always scans every slot and reports multi-sprite overlap.
module sprite_register_bank #(
    parameter int unsigned NUM_SPRITES = 32,
    parameter int unsigned SPRITE_SIZE = 20,
    parameter logic [8:0]  BG_CODE     = 9'd1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_en,
    input  logic [4:0]  wr_addr,
    input  logic [27:0] wr_data,
    input  logic        lookup_valid,
    input  logic [17:0] check_value,
    output logic        busy,
    output logic        data_valid,
    output logic [8:0]  data_reg,
    output logic [4:0]  hit_row
`ifdef SPRITE_COLLISION_EN
    ,
    output logic        collision
`endif
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SCAN = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [4:0] LAST_SLOT = 5'(NUM_SPRITES - 1);
    localparam logic [9:0] SIZE10    = 10'(SPRITE_SIZE);

    logic [27:0] slots [NUM_SPRITES];
    logic [1:0]  state;
    logic [4:0]  cnt;
    logic [8:0]  px;
    logic [8:0]  py;

    logic [27:0] cur_slot;
    logic [9:0]  px10, py10, sx10, sy10;
    logic        hit;
    logic [8:0]  cur_off;
    logic [4:0]  cur_row;

    // The slot array is read before this edge's write lands, so a same-cycle write
    // to the examined slot cannot influence that examination.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < NUM_SPRITES; i++) begin
                slots[i] <= '0;
            end
        end else if (wr_en) begin
            slots[wr_addr] <= wr_data;
        end
    end

    // Coordinates widened to 10 bits so a sprite near x=511 does not wrap to 0.
    always_comb begin
        cur_slot = slots[cnt];
        px10     = {1'b0, px};
        py10     = {1'b0, py};
        sx10     = {1'b0, cur_slot[17:9]};
        sy10     = {1'b0, cur_slot[8:0]};
        cur_off  = cur_slot[26:18];
        cur_row  = 5'(py10 - sy10);
        hit      = cur_slot[27]
                   && (px10 >= sx10) && (px10 < sx10 + SIZE10)
                   && (py10 >= sy10) && (py10 < sy10 + SIZE10);
    end

    assign busy = (state != IDLE);

`ifdef SPRITE_COLLISION_EN
    logic       found;
    logic       coll_acc;
    logic [8:0] acc_off;
    logic [4:0] acc_row;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            cnt        <= '0;
            px         <= '0;
            py         <= '0;
            data_valid <= 1'b0;
            data_reg   <= BG_CODE;
            hit_row    <= '0;
`ifdef SPRITE_COLLISION_EN
            collision  <= 1'b0;
            found      <= 1'b0;
            coll_acc   <= 1'b0;
            acc_off    <= '0;
            acc_row    <= '0;
`endif
        end else begin
            data_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (lookup_valid) begin
                        px    <= check_value[17:9];
                        py    <= check_value[8:0];
                        cnt   <= '0;
                        state <= SCAN;
`ifdef SPRITE_COLLISION_EN
                        found    <= 1'b0;
                        coll_acc <= 1'b0;
`endif
                    end
                end
                SCAN: begin
`ifdef SPRITE_COLLISION_EN
                    // First hit is remembered; any later hit only marks a collision.
                    if (hit) begin
                        if (!found) begin
                            found   <= 1'b1;
                            acc_off <= cur_off;
                            acc_row <= cur_row;
                        end else begin
                            coll_acc <= 1'b1;
                        end
                    end
                    if (cnt == LAST_SLOT) begin
                        state      <= DONE;
                        data_valid <= 1'b1;
                        collision  <= coll_acc | (hit & found);
                        if (found) begin
                            data_reg <= acc_off;
                            hit_row  <= acc_row;
                        end else if (hit) begin
                            data_reg <= cur_off;
                            hit_row  <= cur_row;
                        end else begin
                            data_reg <= BG_CODE;
                            hit_row  <= '0;
                        end
                    end else begin
                        cnt <= cnt + 5'd1;
                    end
`else
                    if (hit) begin
                        state      <= DONE;
                        data_valid <= 1'b1;
                        data_reg   <= cur_off;
                        hit_row    <= cur_row;
                    end else if (cnt == LAST_SLOT) begin
                        state      <= DONE;
                        data_valid <= 1'b1;
                        data_reg   <= BG_CODE;
                        hit_row    <= '0;
                    end else begin
                        cnt <= cnt + 5'd1;
                    end
`endif
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sprite_register_bank.sv
// Scoreboard bench for sprite_register_bank: directed lookups queue expected results,
// a negedge monitor checks them against each data_valid pulse.
module tb_sprite_register_bank;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        wr_en = 1'b0;
    logic [4:0]  wr_addr = '0;
    logic [27:0] wr_data = '0;
    logic        lookup_valid = 1'b0;
    logic [17:0] check_value = '0;
    logic        busy;
    logic        data_valid;
    logic [8:0]  data_reg;
    logic [4:0]  hit_row;
`ifdef SPRITE_COLLISION_EN
    logic        collision;
    localparam bit COL = 1'b1;
`else
    localparam bit COL = 1'b0;
`endif

    localparam logic [8:0] BG = 9'd1;

    sprite_register_bank #(
        .NUM_SPRITES(32),
        .SPRITE_SIZE(20),
        .BG_CODE(9'd1)
    ) dut (
        .clk(clk),
        .reset(reset),
        .wr_en(wr_en),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .lookup_valid(lookup_valid),
        .check_value(check_value),
        .busy(busy),
        .data_valid(data_valid),
        .data_reg(data_reg),
        .hit_row(hit_row)
`ifdef SPRITE_COLLISION_EN
        ,
        .collision(collision)
`endif
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [8:0]  off;
        logic [4:0]  row;
        int unsigned cyc;
        logic        col;
    } exp_t;

    exp_t q[$];
    int unsigned total = 0;
    int unsigned bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Result expected k+1 edges after accept for a hit in slot k; full scan otherwise.
    function automatic int unsigned lat(input int unsigned k);
        return COL ? 32 : k + 1;
    endfunction

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset && data_valid === 1'b1) begin
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL spurious_valid: got data_reg=%0d expected no pulse", data_reg);
                end else begin
                    e = q.pop_front();
                    chk("data_reg", 32'(data_reg), 32'(e.off));
                    chk("hit_row", 32'(hit_row), 32'(e.row));
                    chk("latency", cyc, e.cyc);
`ifdef SPRITE_COLLISION_EN
                    chk("collision", 32'(collision), 32'(e.col));
`endif
                end
            end
        end
    end

    task automatic wr(input logic [4:0] a, input logic [27:0] d);
        @(negedge clk);
        wr_en = 1'b1;
        wr_addr = a;
        wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic lookup(input logic [8:0] x, input logic [8:0] y, input logic [8:0] off,
                          input logic [4:0] row, input int unsigned l, input logic col,
                          output int unsigned acc);
        exp_t e;
        @(negedge clk);
        check_value = {x, y};
        lookup_valid = 1'b1;
        acc = cyc + 1;
        e.off = off;
        e.row = row;
        e.cyc = acc + l;
        e.col = col;
        q.push_back(e);
        @(negedge clk);
        lookup_valid = 1'b0;
    endtask

    task automatic wait_done();
        int unsigned n = 0;
        while (q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL timeout: got %0d pending results expected 0", q.size());
            q.delete();
        end
        @(negedge clk);
    endtask

    initial begin : stim
        int unsigned acc;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_valid", 32'(data_valid), 0);
        chk("rst_data_reg", 32'(data_reg), 32'(BG));
        chk("rst_hit_row", 32'(hit_row), 0);
        reset = 1'b1;

        // Background: nothing programmed
        lookup(9'd100, 9'd50, BG, 5'd0, 32, 1'b0, acc);
        wait_done();

        // Single hit in slot 3, bottom-right corner, then one pixel past it
        wr(5'd3, {1'b1, 9'd40, 9'd100, 9'd50});
        lookup(9'd119, 9'd69, 9'd40, 5'd19, lat(3), 1'b0, acc);
        wait_done();
        lookup(9'd120, 9'd69, BG, 5'd0, 32, 1'b0, acc);
        wait_done();

        // Overlapping slots 2 and 7; lower index wins; a request while busy is dropped
        wr(5'd2, {1'b1, 9'd5, 9'd0, 9'd0});
        wr(5'd7, {1'b1, 9'd9, 9'd5, 9'd5});
        lookup(9'd10, 9'd10, 9'd5, 5'd10, lat(2), 1'b1, acc);
        @(negedge clk);
        chk("busy_during_scan", 32'(busy), 1);
        lookup_valid = 1'b1;
        check_value = {9'd119, 9'd69};
        @(negedge clk);
        lookup_valid = 1'b0;
        wait_done();
        repeat (40) @(negedge clk);
        chk("busy_after_ignored", 32'(busy), 0);

        // Right-edge sprite at x=470 covers 470..489 and must not wrap to low x
        wr(5'd0, {1'b1, 9'd77, 9'd470, 9'd0});
        lookup(9'd5, 9'd300, BG, 5'd0, 32, 1'b0, acc);
        wait_done();
        lookup(9'd489, 9'd5, 9'd77, 5'd5, lat(0), 1'b0, acc);
        wait_done();
        lookup(9'd490, 9'd5, BG, 5'd0, 32, 1'b0, acc);
        wait_done();

        // Writes during the scan: slot 10 (ahead of counter) used, slot 2 (behind) not
        lookup(9'd205, 9'd210, 9'd100, 5'd10, lat(10), 1'b0, acc);
        while (cyc != acc + 4) @(negedge clk);
        wr_en = 1'b1;
        wr_addr = 5'd10;
        wr_data = {1'b1, 9'd100, 9'd200, 9'd200};
        @(negedge clk);
        wr_addr = 5'd2;
        wr_data = {1'b1, 9'd50, 9'd200, 9'd200};
        @(negedge clk);
        wr_en = 1'b0;
        wait_done();

        // Reset mid-scan: aborted lookup yields no pulse, outputs clear at once
        @(negedge clk);
        check_value = {9'd300, 9'd300};
        lookup_valid = 1'b1;
        @(negedge clk);
        lookup_valid = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_valid", 32'(data_valid), 0);
        chk("midrst_data_reg", 32'(data_reg), 32'(BG));
        chk("midrst_hit_row", 32'(hit_row), 0);
        @(negedge clk);
        reset = 1'b1;
        lookup(9'd205, 9'd210, BG, 5'd0, 32, 1'b0, acc);
        wait_done();
        lookup(9'd489, 9'd5, BG, 5'd0, 32, 1'b0, acc);
        wait_done();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
